// File: rtl/booth_mul_seq.sv
// Operand sequencer and result capture around a 4x4 sequential radix-2 Booth core.
// Optional running accumulator of products is enabled by defining BOOTH_SEQ_MAC_EN.
module booth_mul_seq #(
  parameter int unsigned STEPS = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             mul_load,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_prod,
  output logic             out_amin,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] step_cnt;
  logic             cap_pend;
  logic             accept;
  logic             capture;
  logic             release_out;

  assign accept      = in_valid && in_ready;
  assign capture     = (state == HOLD) && cap_pend;
  assign release_out = (state == HOLD) && out_valid && out_ready;

  // in_ready is forced low during reset even though the state already reads IDLE.
  assign in_ready = rst_n && (state == IDLE);
  assign mul_load = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN:  if (step_cnt == LAST_STEP) state_nxt = HOLD;
      HOLD: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= in_a;
      mul_b <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (state == LOAD) begin
      step_cnt <= '0;
    end else if (state == RUN) begin
      step_cnt <= step_cnt + CNT_W'(1);
    end
  end

  // The core's 4th step lands on the RUN->HOLD edge, so the product is sampled
  // one edge later, on the first edge spent in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_pend <= 1'b0;
    end else if ((state == RUN) && (step_cnt == LAST_STEP)) begin
      cap_pend <= 1'b1;
    end else if (state == HOLD) begin
      cap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_amin  <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_prod  <= mul_prod;
      out_amin  <= (mul_a == 4'b1000);
    end else if (release_out) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BOOTH_SEQ_MAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
    end else if (acc_clr) begin
      acc_out <= '0;
    end else if (capture) begin
      acc_out <= acc_out + ACC_W'($signed(mul_prod));
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign acc_out        = '0;
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq with a behavioural radix-2 Booth core on the mul_* side.
module tb_booth_mul_seq;

  localparam int unsigned ACC_W = 12;
`ifdef BOOTH_SEQ_MAC_EN
  localparam int MAC = 1;
`else
  localparam int MAC = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             mul_load;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_prod;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_prod;
  logic             out_amin;
  logic             acc_clr;
  logic [ACC_W-1:0] acc_out;

  int vectors = 0;
  int miscompares = 0;

  booth_mul_seq #(.STEPS(4), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_load  (mul_load),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prod  (mul_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_amin  (out_amin),
    .acc_clr   (acc_clr),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Booth core: A:Q:q-1 register, add/sub multiplicand, arithmetic shift right.
  logic [3:0] core_a = '0;
  logic [3:0] core_q = '0;
  logic       core_q1 = 1'b0;
  logic [3:0] core_sum;
  assign mul_prod = {core_a, core_q};

  always_comb begin
    core_sum = core_a;
    case ({core_q[0], core_q1})
      2'b01:   core_sum = core_a + mul_a;
      2'b10:   core_sum = core_a - mul_a;
      default: core_sum = core_a;
    endcase
  end

  always @(posedge clk) begin
    if (mul_load) begin
      core_a  <= '0;
      core_q  <= mul_b;
      core_q1 <= 1'b0;
    end else begin
      core_a  <= {core_sum[3], core_sum[3:1]};
      core_q  <= {core_sum[0], core_q[3:1]};
      core_q1 <= core_q[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int lows;
  int lat;
  int cyc;
  int stale;
  logic stable;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    acc_clr = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mul_load", 32'(mul_load), 32'd1);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_out_amin", 32'(out_amin), 32'd0);
    chk("rst_acc_out", 32'(acc_out), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Reset asserted mid-RUN
    out_ready = 1'b1;
    accept(4'd2, 4'd3);
    repeat (2) @(negedge clk);
    chk("midrun_mul_load", 32'(mul_load), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_mul_load", 32'(mul_load), 32'd1);
    chk("midrst_mul_a", 32'(mul_a), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_capture", 32'(stale), 32'd0);
    chk("no_stale_prod", 32'(out_prod), 32'd0);

    // -4 x -5, out_ready high: latency 6, mul_load low 4 cycles
    accept(4'd12, 4'd11);
    lows = 0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      if (!mul_load) lows++;
      if (out_valid && lat < 0) lat = i;
      @(negedge clk);
    end
    chk("m12x11_latency", 32'(lat), 32'd6);
    chk("m12x11_load_low", 32'(lows), 32'd4);
    chk("m12x11_prod", 32'(out_prod), 32'h14);
    chk("m12x11_amin", 32'(out_amin), 32'd0);
    chk("m12x11_released", 32'(out_valid), 32'd0);
    chk("m12x11_ready", 32'(in_ready), 32'd1);

    // Back-to-back (13,9) then (12,14) with in_valid held
    in_valid = 1'b1;
    in_a = 4'd13;
    in_b = 4'd9;
    #1;
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_a = 4'd12;
    in_b = 4'd14;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      if (!in_ready) lows++;
      @(negedge clk);
    end
    if (!in_ready) lows++;
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_first_prod", 32'(out_prod), 32'h15);
    @(negedge clk);
    chk("b2b_ready_low_cycles", 32'(lows), 32'd7);
    chk("b2b_ready_again", 32'(in_ready), 32'd1);
    chk("b2b_valid_dropped", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_mul_a", 32'(mul_a), 32'd12);
    wait_valid(cyc);
    chk("b2b_second_latency", 32'(cyc), 32'd6);
    chk("b2b_second_prod", 32'(out_prod), 32'h08);
    chk("mac_sum_49", 32'(acc_out), MAC ? 32'd49 : 32'd0);
    @(negedge clk);

    // Stall on 12x11 with acc_clr held across the capture
    out_ready = 1'b0;
    acc_clr = 1'b1;
    accept(4'd12, 4'd11);
    wait_valid(cyc);
    chk("stall_latency", 32'(cyc), 32'd6);
    in_valid = 1'b1;
    in_a = 4'd8;
    in_b = 4'd3;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_prod !== 8'h14 || in_ready !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    chk("stall_stable", 32'(stable), 32'd1);
    chk("mac_clear_wins", 32'(acc_out), 32'd0);
    acc_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid_dropped", 32'(out_valid), 32'd0);
    chk("hs_not_accepted_yet", 32'(mul_a), 32'd12);
    chk("hs_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("next_accepted_mul_a", 32'(mul_a), 32'd8);
    chk("next_accepted_ready", 32'(in_ready), 32'd0);

    // -8 x 3: amin flagged, raw core product passed through
    wait_valid(cyc);
    chk("amin_latency", 32'(cyc), 32'd6);
    chk("amin_flag", 32'(out_amin), 32'd1);
    chk("amin_prod", 32'(out_prod), 32'h18);
    chk("mac_after_amin", 32'(acc_out), MAC ? 32'd24 : 32'd0);
    @(negedge clk);

    // 2 x 3 clears amin
    accept(4'd2, 4'd3);
    wait_valid(cyc);
    chk("m2x3_prod", 32'(out_prod), 32'h06);
    chk("m2x3_amin", 32'(out_amin), 32'd0);
    chk("mac_after_m2x3", 32'(acc_out), MAC ? 32'd30 : 32'd0);
    @(negedge clk);
    chk("m2x3_released", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
